// File: rtl/gesture_pkg.sv
// ============================================================================
// Module      : gesture_pkg
// Description : Shared types and constants for the gesture hold controller:
//               FSM state encoding, gesture code values, sensor flag bit
//               positions, timer width and a display-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gesture_pkg;

  // Widths of the sensor flag word, the encoded code and the display bus
  localparam int FLAG_W  = 9;
  localparam int CODE_W  = 4;
  localparam int DISP_W  = 6;
  localparam int TIMER_W = 26;
  localparam int TOTAL_W = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    HOLD  = 2'd2
  } gest_state_t;

  // Gesture codes shown on the display
  localparam logic [CODE_W-1:0] GEST_NONE     = 4'd0;
  localparam logic [CODE_W-1:0] GEST_UP       = 4'd1;
  localparam logic [CODE_W-1:0] GEST_DOWN     = 4'd2;
  localparam logic [CODE_W-1:0] GEST_LEFT     = 4'd3;
  localparam logic [CODE_W-1:0] GEST_RIGHT    = 4'd4;
  localparam logic [CODE_W-1:0] GEST_FORWARD  = 4'd5;
  localparam logic [CODE_W-1:0] GEST_BACKWARD = 4'd6;
  localparam logic [CODE_W-1:0] GEST_CW       = 4'd7;
  localparam logic [CODE_W-1:0] GEST_CCW      = 4'd8;
  localparam logic [CODE_W-1:0] GEST_WAVE     = 4'd9;

  // Bit positions inside the sensor flag word
  localparam int BIT_UP       = 0;
  localparam int BIT_DOWN     = 1;
  localparam int BIT_LEFT     = 2;
  localparam int BIT_RIGHT    = 3;
  localparam int BIT_FORWARD  = 4;
  localparam int BIT_BACKWARD = 5;
  localparam int BIT_CW       = 6;
  localparam int BIT_CCW      = 7;
  localparam int BIT_WAVE     = 8;

  // Widen a gesture code to the display driver's data bus (upper bits zero)
  function automatic logic [DISP_W-1:0] code_to_disp(input logic [CODE_W-1:0] code);
    return {{(DISP_W-CODE_W){1'b0}}, code};
  endfunction

endpackage : gesture_pkg

`default_nettype wire

// File: rtl/gesture_prio_enc.sv
// ============================================================================
// Module      : gesture_prio_enc
// Description : Combinational lowest-set-bit encoder for the 9-bit gesture
//               flag word. Output is bit index + 1, or GEST_NONE when no flag
//               is set. Shared with the sensor debug path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gesture_prio_enc
  import gesture_pkg::*;
(
  input  logic [FLAG_W-1:0] flag,
  output logic [CODE_W-1:0] code
);

  // Lowest bit has highest priority, so it is tested first
  always_comb begin
    code = GEST_NONE;
    if      (flag[BIT_UP])       code = GEST_UP;
    else if (flag[BIT_DOWN])     code = GEST_DOWN;
    else if (flag[BIT_LEFT])     code = GEST_LEFT;
    else if (flag[BIT_RIGHT])    code = GEST_RIGHT;
    else if (flag[BIT_FORWARD])  code = GEST_FORWARD;
    else if (flag[BIT_BACKWARD]) code = GEST_BACKWARD;
    else if (flag[BIT_CW])       code = GEST_CW;
    else if (flag[BIT_CCW])      code = GEST_CCW;
    else if (flag[BIT_WAVE])     code = GEST_WAVE;
  end

endmodule : gesture_prio_enc

`default_nettype wire

// File: rtl/gesture_hold_ctrl.sv
// ============================================================================
// Module      : gesture_hold_ctrl
// Description : Accepts gesture sensor reads, priority-encodes them to a
//               digit code 1..9 and holds that code on the seven-segment
//               display for HOLD_CYCLES. For the first GUARD_CYCLES after an
//               accept, further reads are ignored to reject sensor chatter.
//               Optional macro GESTURE_TOTAL_EN enables the 8-bit count of
//               accepted gestures on gest_total; otherwise gest_total is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gesture_hold_ctrl
  import gesture_pkg::*;
#(
  parameter int HOLD_CYCLES  = 48_000_000,
  parameter int GUARD_CYCLES = 2_400_000
) (
  input  logic               clk_24m,
  input  logic               rst_n,
  input  logic               gest_valid,
  input  logic [FLAG_W-1:0]  gest_flag,
  output logic [DISP_W-1:0]  disp_code,
  output logic               new_pulse,
  output logic               busy,
  output logic [TOTAL_W-1:0] gest_total
);

  // Terminal timer values; the timer counts 0..N-1 so N-1 ends the window
  localparam logic [TIMER_W-1:0] c_guard_last = TIMER_W'(GUARD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_hold_last  = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_timer_one  = TIMER_W'(1);

  gest_state_t        r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [CODE_W-1:0]  r_code;
  logic               r_pulse;
  logic               r_busy;

  logic [CODE_W-1:0]  w_code;
  logic               w_flag_any;
  logic               w_open;
  logic               w_accept;

  gesture_prio_enc u_prio_enc (
    .flag (gest_flag),
    .code (w_code)
  );

  // A read is a gesture only if some flag is set; GUARD never accepts
  assign w_flag_any = |gest_flag;
  assign w_open     = (r_state == IDLE) || (r_state == HOLD);
  assign w_accept   = gest_valid & w_flag_any & w_open;

  // Hold FSM with timer; all outputs are registered here
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_code  <= GEST_NONE;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_accept) begin
            r_state <= GUARD;
            r_code  <= w_code;
            r_pulse <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        GUARD: begin
          // Timer keeps running into HOLD so the total window is HOLD_CYCLES
          r_timer <= r_timer + c_timer_one;
          if (r_timer == c_guard_last) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // An accept (even a repeat of the same code) beats expiry
          if (w_accept) begin
            r_state <= GUARD;
            r_timer <= '0;
            r_code  <= w_code;
            r_pulse <= 1'b1;
          end else if (r_timer == c_hold_last) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_code  <= GEST_NONE;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + c_timer_one;
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
          r_code  <= GEST_NONE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign disp_code = code_to_disp(r_code);
  assign new_pulse = r_pulse;
  assign busy      = r_busy;

`ifdef GESTURE_TOTAL_EN
  logic [TOTAL_W-1:0] r_total;

  // Count every cycle on which new_pulse is high; wraps naturally at 255
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
    end else if (r_pulse) begin
      r_total <= r_total + TOTAL_W'(1);
    end
  end

  assign gest_total = r_total;
`else
  assign gest_total = '0;
`endif

endmodule : gesture_hold_ctrl

`default_nettype wire

// File: tb/tb_gesture_hold_ctrl.sv
// ============================================================================
// Module      : tb_gesture_hold_ctrl
// Description : Self-checking bench for gesture_hold_ctrl with HOLD_CYCLES=100
//               and GUARD_CYCLES=10. Table-driven encoder vectors plus
//               hand-written timing sequences; expected values go through a
//               scoreboard queue. Honours GESTURE_TOTAL_EN for gest_total.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gesture_hold_ctrl;

  localparam int HOLD  = 100;
  localparam int GUARD = 10;

  logic       clk_24m    = 1'b0;
  logic       rst_n      = 1'b0;
  logic       gest_valid = 1'b0;
  logic [8:0] gest_flag  = '0;
  logic [5:0] disp_code;
  logic       new_pulse;
  logic       busy;
  logic [7:0] gest_total;

  gesture_hold_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk_24m    (clk_24m),
    .rst_n      (rst_n),
    .gest_valid (gest_valid),
    .gest_flag  (gest_flag),
    .disp_code  (disp_code),
    .new_pulse  (new_pulse),
    .busy       (busy),
    .gest_total (gest_total)
  );

  always #5 clk_24m = ~clk_24m;

  typedef struct {
    logic [5:0] code;
    logic       pulse;
    logic       busy;
    logic [7:0] total;
  } exp_t;

  typedef struct {
    logic [8:0] flag;
    logic [5:0] code;
    logic       pulse;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  int checks   = 0;
  int failures = 0;
  int accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_total(input int n);
`ifdef GESTURE_TOTAL_EN
    return 8'(n % 256);
`else
    return 8'd0;
`endif
  endfunction

  // One clock: drive inputs, let the edge sample them, sample outputs 1 unit later
  task automatic step(input logic v, input logic [8:0] f);
    gest_valid = v;
    gest_flag  = f;
    @(posedge clk_24m);
    #1;
    gest_valid = 1'b0;
    gest_flag  = '0;
  endtask

  // Strobe a read; expected result is queued before the edge and checked after
  task automatic gesture(input string name, input logic [8:0] f, input logic [5:0] code,
                         input logic pulse, input logic bsy);
    exp_t e;
    e.code  = code;
    e.pulse = pulse;
    e.busy  = bsy;
    e.total = exp_total(accepted);
    sb_q.push_back(e);
    step(1'b1, f);
    if (pulse) accepted++;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_code"},  32'(disp_code),  32'(e.code));
      chk({name, "_pulse"}, 32'(new_pulse),  32'(e.pulse));
      chk({name, "_busy"},  32'(busy),       32'(e.busy));
      chk({name, "_total"}, 32'(gest_total), 32'(e.total));
    end
  endtask

  // Idle cycles with the display expected steady and no pulse
  task automatic idle_run(input int n, input string name, input logic [5:0] code, input logic bsy);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 9'd0);
      if (disp_code !== code || busy !== bsy || new_pulse !== 1'b0) bad++;
    end
    chk({name, "_bad_cycles"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [5:0] cur;
    logic [8:0] f;

    vecs[0] = '{flag: 9'b000001000, code: 6'd4, pulse: 1'b1};
    vecs[1] = '{flag: 9'b100000110, code: 6'd2, pulse: 1'b1};
    vecs[2] = '{flag: 9'b000000001, code: 6'd1, pulse: 1'b1};
    vecs[3] = '{flag: 9'b100000000, code: 6'd9, pulse: 1'b1};
    vecs[4] = '{flag: 9'b000000000, code: 6'd9, pulse: 1'b0};
    vecs[5] = '{flag: 9'b010000000, code: 6'd8, pulse: 1'b1};
    vecs[6] = '{flag: 9'b111111111, code: 6'd1, pulse: 1'b1};
    vecs[7] = '{flag: 9'b001100000, code: 6'd6, pulse: 1'b1};
    vecs[8] = '{flag: 9'b000010000, code: 6'd5, pulse: 1'b1};
    vecs[9] = '{flag: 9'b000000100, code: 6'd3, pulse: 1'b1};

    // Reset state, then 200 quiet cycles
    repeat (3) step(1'b0, 9'd0);
    chk("rst_code",  32'(disp_code),  32'd0);
    chk("rst_pulse", 32'(new_pulse),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_total", 32'(gest_total), 32'd0);
    rst_n = 1'b1;
    idle_run(200, "idle", 6'd0, 1'b0);

    // Encoder table, each read landing in HOLD of the previous accept
    cur = 6'd0;
    for (int i = 0; i < 10; i++) begin
      gesture($sformatf("vec%0d", i), vecs[i].flag, vecs[i].code, vecs[i].pulse, 1'b1);
      if (vecs[i].pulse) cur = vecs[i].code;
      idle_run(14, $sformatf("vec%0d_hold", i), cur, 1'b1);
    end
    repeat (100) step(1'b0, 9'd0);
    chk("tbl_back_idle", 32'(disp_code), 32'd0);

    // Single gesture: exact pulse width and HOLD-cycle display window
    gesture("single", 9'b000001000, 6'd4, 1'b1, 1'b1);
    step(1'b0, 9'd0);
    chk("single_pulse_width", 32'(new_pulse), 32'd0);
    idle_run(98, "single_hold", 6'd4, 1'b1);
    step(1'b0, 9'd0);
    chk("single_expire_code", 32'(disp_code), 32'd0);
    chk("single_expire_busy", 32'(busy),      32'd0);

    // Zero flag with strobe in IDLE is not a gesture
    gesture("zero_idle", 9'd0, 6'd0, 1'b0, 1'b0);

    // Guard rejection, then retrigger from HOLD restarts the hold
    gesture("grd_first", 9'b000000001, 6'd1, 1'b1, 1'b1);
    idle_run(4, "grd_a", 6'd1, 1'b1);
    gesture("grd_ign", 9'b000000100, 6'd1, 1'b0, 1'b1);
    idle_run(9, "grd_b", 6'd1, 1'b1);
    gesture("grd_hold_acc", 9'b000000100, 6'd3, 1'b1, 1'b1);
    idle_run(99, "grd_rehold", 6'd3, 1'b1);
    step(1'b0, 9'd0);
    chk("grd_expire_code", 32'(disp_code), 32'd0);

    // Accept on the exact expiry cycle wins and re-enters GUARD
    gesture("coll_first", 9'b000000010, 6'd2, 1'b1, 1'b1);
    idle_run(99, "coll_hold", 6'd2, 1'b1);
    gesture("coll_accept", 9'b010000000, 6'd8, 1'b1, 1'b1);
    idle_run(2, "coll_g", 6'd8, 1'b1);
    gesture("coll_guard_ign", 9'b000000001, 6'd8, 1'b0, 1'b1);
    idle_run(96, "coll_rehold", 6'd8, 1'b1);
    step(1'b0, 9'd0);
    chk("coll_expire_code", 32'(disp_code), 32'd0);
    chk("coll_expire_busy", 32'(busy),      32'd0);

    // Asynchronous reset mid-hold clears outputs without a clock edge
    gesture("rst_pre", 9'b000100000, 6'd6, 1'b1, 1'b1);
    idle_run(20, "rst_hold", 6'd6, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_code",  32'(disp_code),  32'd0);
    chk("async_rst_busy",  32'(busy),       32'd0);
    chk("async_rst_pulse", 32'(new_pulse),  32'd0);
    chk("async_rst_total", 32'(gest_total), 32'd0);
    accepted = 0;
    repeat (2) step(1'b0, 9'd0);
    rst_n = 1'b1;
    step(1'b0, 9'd0);

    // 257 accepts to exercise the total counter wrap
    for (int i = 0; i < 257; i++) begin
      f = 9'd1 << (i % 9);
      gesture("cnt", f, 6'((i % 9) + 1), 1'b1, 1'b1);
      repeat (10) step(1'b0, 9'd0);
    end
    chk("total_wrap", 32'(gest_total), 32'(exp_total(accepted)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gesture_hold_ctrl

`default_nettype wire

// File: doc/gesture_hold_ctrl.md
Name: gesture_hold_ctrl

Overview:
- Sits between the gesture-sensor reader and the 4-digit seven-segment driver.
- Takes per-read gesture flag words and priority-encodes them to a digit code 1..9.
- Holds the accepted code on the display for a fixed time, with a guard window that rejects sensor chatter, then returns to 0.
- disp_code drives the display driver's data[5:0] input directly.

Parameters:
- HOLD_CYCLES, 48_000_000: clk_24m cycles a code stays displayed after acceptance (2 s).
- GUARD_CYCLES, 2_400_000: cycles after acceptance during which new gestures are ignored (0.1 s).
- Legal range: 2 <= GUARD_CYCLES < HOLD_CYCLES < 2^26.

Ports:
- clk_24m  in  1  system clock, 24 MHz
- rst_n  in  1  reset, asynchronous, active-low
- gest_valid  in  1  one-cycle strobe: gest_flag is a fresh sensor read
- gest_flag  in  9  bit0 up, bit1 down, bit2 left, bit3 right, bit4 forward, bit5 backward, bit6 cw, bit7 ccw, bit8 wave
- disp_code  out  6  code to display: 0 idle, 1..9 gesture; bits [5:4] always 0
- new_pulse  out  1  one-cycle pulse when a gesture is accepted
- busy  out  1  high in GUARD or HOLD
- gest_total  out  8  count of accepted gestures (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low, clocked on clk_24m.
- Reset values: disp_code 0, new_pulse 0, busy 0, gest_total 0, state IDLE, timer 0.
- Reset asserted mid-hold clears all outputs immediately, with no clock needed.
- Encoding:
  - Lowest set bit of gest_flag wins; code = bit index + 1.
  - gest_flag == 0 with gest_valid is not a gesture and is ignored in every state.
- Accept condition: gest_valid & |gest_flag & (state is IDLE or HOLD).
- Latency: gesture sampled at edge N gives disp_code, new_pulse and busy updated at edge N+1. new_pulse is high for exactly one cycle.
- Timer: 26-bit up-counter, cleared to 0 on accept, increments every cycle in GUARD and HOLD, held at 0 in IDLE.
- FSM:
  - IDLE: disp_code 0, busy 0. Accept -> GUARD, load code.
  - GUARD: inputs ignored, including nonzero flags. When timer == GUARD_CYCLES-1 -> HOLD.
  - HOLD: accept -> GUARD, timer cleared, new code loaded. A repeat of the same code is also accepted: it retriggers, pulses new_pulse and restarts the hold. When timer == HOLD_CYCLES-1 with no accept -> IDLE, disp_code 0.
- Simultaneous accept and expiry in HOLD: accept wins (GUARD, new code, timer 0).
- Total display time from an isolated accept: disp_code nonzero for exactly HOLD_CYCLES cycles.

Optional Feature:
- Macro GESTURE_TOTAL_EN.
- Defined:
  - gest_total increments by 1 on every cycle where new_pulse is asserted.
  - Wraps 255 -> 0.
  - Cleared only by rst_n.
- Undefined: gest_total tied to 8'd0 and no counter flops are generated. The port list is unchanged.

Decomposition:
- Package gesture_pkg holds:
  - FSM state encoding: IDLE 2'd0, GUARD 2'd1, HOLD 2'd2.
  - Gesture code constants: GEST_NONE 0, GEST_UP 1 .. GEST_WAVE 9.
  - Gesture flag bit positions.
  - Timer width 26.
- One sub-module, gesture_prio_enc: purely combinational 9-bit -> 4-bit lowest-set-bit encoder, output 0 when no bit is set, reused by the sensor debug path.

Test Plan:
All scenarios run with HOLD_CYCLES=100, GUARD_CYCLES=10.
1. Reset then idle: no strobes for 200 cycles -> disp_code 0, busy 0, new_pulse never high.
2. Single gesture: gest_valid with flag 9'b000001000 at edge N -> disp_code 4 and new_pulse 1 at N+1; new_pulse 0 at N+2; disp_code 4 through N+100, then 0 at N+101; busy falls at the same edge.
3. Priority and zero flag: flag 9'b100000110 -> disp_code 2. Later, flag 0 with gest_valid in IDLE -> no change, no pulse.
4. Guard rejection: accept code 1 at N, then flag 9'b000000100 at N+5 -> ignored, disp_code stays 1. Same flag at N+15 (HOLD) -> disp_code 3 at N+16 and hold restarts, so display returns to 0 at N+116.
5. Expiry collision and reset: accept at the exact HOLD_CYCLES-1 cycle -> new code displayed, state GUARD. Then assert rst_n low mid-hold -> disp_code 0 immediately, async.
6. GESTURE_TOTAL_EN defined: 257 accepted gestures -> gest_total == 1. With macro undefined -> gest_total stays 0 throughout.
